// File: rtl/stage1_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Defines the fetch-to-decode bundle and fetch sizing constants.
package stage1_fetch_pkg;

    // Architectural address/data width.
    localparam int XLEN = 32;

    // Size of one instruction in bytes (pc step).
    localparam int INSTR_BYTES = 4;

    // Output buffer entries; fixed, the credit logic assumes 2.
    localparam int BUF_DEPTH = 2;

    // Default reset program counter.
    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    // Raw instruction word as fetched, before decode.
    typedef logic [31:0] instruction_undecoded_t;

    // One fetched instruction tagged with its address.
    typedef struct packed {
        logic [XLEN-1:0]        program_counter;
        instruction_undecoded_t instruction;
    } fetch_to_decode_t;

endpackage

// File: rtl/stage1_fetch_fifo.sv
// Two-entry synchronous FIFO buffering fetched instructions.
// Ports: clk, rst (sync active-low), push/push_data, pop, flush, head, count.
// Flush beats push; pop on an empty FIFO is ignored.
module stage1_fetch_fifo
    import stage1_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_to_decode_t push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_to_decode_t head,
    output logic [1:0]       count
);

    fetch_to_decode_t entries [BUF_DEPTH];

    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count_q;
    logic       pop_ok;

    assign pop_ok = pop && (count_q != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop_ok})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head comes straight from storage, never from the memory bus.
    assign head  = entries[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/stage1_fetch.sv
// Instruction fetch stage: pc, memory requests, 2-entry output buffer.
// Ports: clk, rst (sync active-low), instr_port_* (sync memory),
//  axis_fetch_to_decode_* (stream to decode), redirect_valid/redirect_pc.
// Optional macro FETCH_STATS_EN adds stat_fetched/stat_flushed counters.
module stage1_fetch
    import stage1_fetch_pkg::*;
#(
    parameter int              WIDTH        = XLEN,
    parameter logic [WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    output logic             instr_port_enable,
    output logic [WIDTH-1:0] instr_port_address,
    input  logic [31:0]      instr_port_data,
    output logic             axis_fetch_to_decode_tvalid,
    input  logic             axis_fetch_to_decode_tready,
    output fetch_to_decode_t axis_fetch_to_decode_tdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]      stat_fetched,
    output logic [31:0]      stat_flushed
`endif
);

    localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INSTR_BYTES - 1);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] req_pc;
    logic             outstanding;
    logic [1:0]       fifo_count;
    logic [2:0]       occupancy;
    logic             pop;
    logic             push;
    logic             issue;
    logic [WIDTH-1:0] target_pc;
    fetch_to_decode_t push_data;
    fetch_to_decode_t head;

    assign pop = axis_fetch_to_decode_tvalid
               && axis_fetch_to_decode_tready;

    // Entries held or in flight after this cycle's pop;
    // a new request may go out only while that stays below 2.
    assign occupancy = {1'b0, fifo_count}
                     + {2'b00, outstanding}
                     - {2'b00, pop};

    assign issue = rst && !redirect_valid
                && (occupancy < 3'(BUF_DEPTH));

    // A response arriving in a redirect cycle belongs to the
    // abandoned path and is dropped.
    assign push = rst && !redirect_valid && outstanding;

    assign target_pc = redirect_pc & ~LOW_MASK;

    assign push_data.program_counter = req_pc;
    assign push_data.instruction     = instr_port_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_VECTOR;
            req_pc      <= RESET_VECTOR;
            outstanding <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= target_pc;
            outstanding <= 1'b0;
        end else begin
            outstanding <= issue;
            if (issue) begin
                pc     <= pc + PC_STEP;
                req_pc <= pc;
            end
        end
    end

    stage1_fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (fifo_count)
    );

    assign instr_port_enable           = issue;
    assign instr_port_address          = pc;
    assign axis_fetch_to_decode_tvalid = (fifo_count != 2'd0);
    assign axis_fetch_to_decode_tdata  = head;

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_fetched <= 32'd0;
            stat_flushed <= 32'd0;
        end else begin
            if (pop) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (redirect_valid) begin
                stat_flushed <= stat_flushed + 32'd1;
            end
        end
    end
`endif

endmodule
